// File: rtl/cpu6502_interrupt_controller.sv
// 6502 interrupt/reset front end: pin synchronisers, NMI edge latch,
// boundary polling and live vector-low selection with NMI hijack.
module cpu6502_interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       nNMI,
    input  logic       nIRQ,
    input  logic       iFlag,
    input  logic       pollInterrupts,
    input  logic       vectorTaken,
    output logic       interruptPending,
    output logic [1:0] interruptType,
    output logic [7:0] vectorLow,
    output logic       breakFlag,
    output logic       nmiLatchedOut
);

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_IRQ  = 2'b01;
    localparam logic [1:0] T_NMI  = 2'b10;
    localparam logic [1:0] T_RST  = 2'b11;

    logic [SYNC_STAGES-1:0] r_nmiSyncFf;
    logic [SYNC_STAGES-1:0] r_irqSyncFf;
    logic                   r_nmiPrev;
    logic                   r_nmiLatched;
    logic                   r_resetPending;
    logic [1:0]             r_polledType;
    logic                   r_breakFlag;

    logic       w_nmiSync;
    logic       w_irqSync;
    logic       w_nmiEdge;
    logic       w_irqActive;
    logic       w_rstPost;
    logic       w_nmiPost;
    logic [1:0] w_pollType;
    logic [1:0] w_baseType;
    logic [1:0] w_typeNext;
    logic       w_nmiNext;

    assign w_nmiSync   = r_nmiSyncFf[SYNC_STAGES-1];
    assign w_irqSync   = r_irqSyncFf[SYNC_STAGES-1];
    assign w_nmiEdge   = r_nmiPrev & ~w_nmiSync;
    assign w_irqActive = ~w_irqSync & ~iFlag;

    // vectorTaken clears first; a same-cycle poll sees the cleared state
    always_comb begin
        w_rstPost  = r_resetPending & ~vectorTaken;
        w_nmiPost  = r_nmiLatched
                   & ~(vectorTaken & ~r_resetPending);
        w_nmiNext  = w_nmiPost | w_nmiEdge;
        w_baseType = vectorTaken ? T_NONE : r_polledType;
        w_pollType = T_NONE;
        if (w_rstPost)
            w_pollType = T_RST;
        else if (w_nmiPost)
            w_pollType = T_NMI;
        else if (w_irqActive)
            w_pollType = T_IRQ;
        w_typeNext = w_baseType;
        // type encoding is ordered by priority: only upgrade
        if (pollInterrupts && (w_pollType > w_baseType))
            w_typeNext = w_pollType;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_nmiSyncFf    <= '1;
            r_irqSyncFf    <= '1;
            r_nmiPrev      <= 1'b1;
            r_nmiLatched   <= 1'b0;
            r_resetPending <= 1'b1;
            r_polledType   <= T_NONE;
            r_breakFlag    <= 1'b1;
        end else if (enable) begin
            r_nmiSyncFf[0] <= nNMI;
            r_irqSyncFf[0] <= nIRQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_nmiSyncFf[i] <= r_nmiSyncFf[i-1];
                r_irqSyncFf[i] <= r_irqSyncFf[i-1];
            end
            r_nmiPrev      <= w_nmiSync;
            r_nmiLatched   <= w_nmiNext;
            r_resetPending <= w_rstPost;
            r_polledType   <= w_typeNext;
            r_breakFlag    <= (w_typeNext == T_NONE);
        end
    end

    assign interruptPending = (r_polledType != T_NONE);
    assign interruptType    = r_polledType;
    assign breakFlag        = r_breakFlag;
    assign nmiLatchedOut    = r_nmiLatched;
    assign vectorLow        = r_resetPending ? 8'hFC :
                              r_nmiLatched   ? 8'hFA : 8'hFE;

endmodule

// File: tb/tb_cpu6502_interrupt_controller.sv
// Scenario bench for cpu6502_interrupt_controller; expected output
// snapshots are queued with the stimulus and popped after each edge.
module tb_cpu6502_interrupt_controller;

    typedef struct packed {
        logic       pend;
        logic [1:0] typ;
        logic [7:0] vec;
        logic       brk;
        logic       nmi;
    } snap_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       nNMI = 1'b1;
    logic       nIRQ = 1'b1;
    logic       iFlag = 1'b1;
    logic       pollInterrupts = 1'b0;
    logic       vectorTaken = 1'b0;
    logic       interruptPending;
    logic [1:0] interruptType;
    logic [7:0] vectorLow;
    logic       breakFlag;
    logic       nmiLatchedOut;

    int    tests = 0;
    int    fails = 0;
    snap_t sb[$];
    snap_t got;
    snap_t exp;

    cpu6502_interrupt_controller #(.SYNC_STAGES(2)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .nNMI(nNMI),
        .nIRQ(nIRQ),
        .iFlag(iFlag),
        .pollInterrupts(pollInterrupts),
        .vectorTaken(vectorTaken),
        .interruptPending(interruptPending),
        .interruptType(interruptType),
        .vectorLow(vectorLow),
        .breakFlag(breakFlag),
        .nmiLatchedOut(nmiLatchedOut)
    );

    always #5 clock = ~clock;

    function automatic snap_t mk(logic p, logic [1:0] t,
                                 logic [7:0] v, logic b, logic n);
        snap_t s;
        s.pend = p; s.typ = t; s.vec = v; s.brk = b; s.nmi = n;
        return s;
    endfunction

    function automatic snap_t obs();
        return mk(interruptPending, interruptType, vectorLow,
                  breakFlag, nmiLatchedOut);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic poll();
        pollInterrupts = 1'b1; tick(); pollInterrupts = 1'b0;
    endtask

    task automatic take();
        vectorTaken = 1'b1; tick(); vectorTaken = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sb.push_back(mk(0, 2'b00, 8'hFC, 1, 0));
        tick(2);
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL reset_state got=%h exp=%h", got, exp); end
        reset = 1'b0;
        tick(2);
        sb.push_back(mk(1, 2'b11, 8'hFC, 0, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL reset_poll got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL reset_taken got=%h exp=%h", got, exp); end
    endtask

    task automatic test_irq();
        nIRQ = 1'b0; iFlag = 1'b0;
        tick(3);
        sb.push_back(mk(1, 2'b01, 8'hFE, 0, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL irq_poll got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL irq_taken got=%h exp=%h", got, exp); end
        iFlag = 1'b1;
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL irq_masked got=%h exp=%h", got, exp); end
        nIRQ = 1'b1;
        tick(3);
    endtask

    task automatic test_nmi_pulse();
        nNMI = 1'b0;
        tick();
        nNMI = 1'b1;
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        tick();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL nmi_lat2 got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFA, 1, 1));
        tick();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL nmi_lat3 got=%h exp=%h", got, exp); end
        sb.push_back(mk(1, 2'b10, 8'hFA, 0, 1));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL nmi_poll got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL nmi_taken got=%h exp=%h", got, exp); end
    endtask

    task automatic test_nmi_held();
        nNMI = 1'b0;
        sb.push_back(mk(0, 2'b00, 8'hFA, 1, 1));
        tick(20);
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL held_latch got=%h exp=%h", got, exp); end
        poll();
        take();
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        tick(5);
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL held_once got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL held_repoll got=%h exp=%h", got, exp); end
        nNMI = 1'b1;
        tick(3);
    endtask

    task automatic test_hijack();
        nIRQ = 1'b0; iFlag = 1'b0;
        tick(3);
        sb.push_back(mk(1, 2'b01, 8'hFE, 0, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL hij_irq got=%h exp=%h", got, exp); end
        nNMI = 1'b0;
        sb.push_back(mk(1, 2'b01, 8'hFA, 0, 1));
        tick(3);
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL hij_vec got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL hij_taken got=%h exp=%h", got, exp); end
        sb.push_back(mk(1, 2'b01, 8'hFE, 0, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL hij_repoll got=%h exp=%h", got, exp); end
        take();
        nIRQ = 1'b1; nNMI = 1'b1;
        tick(3);
    endtask

    task automatic test_back_to_back();
        nNMI = 1'b0;
        tick(3);
        poll();
        nNMI = 1'b1;
        tick(3);
        nNMI = 1'b0;
        tick(2);
        sb.push_back(mk(0, 2'b00, 8'hFA, 1, 1));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL b2b_keep got=%h exp=%h", got, exp); end
        sb.push_back(mk(1, 2'b10, 8'hFA, 0, 1));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL b2b_poll got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL b2b_taken got=%h exp=%h", got, exp); end
        nNMI = 1'b1;
        tick(3);
    endtask

    task automatic test_enable();
        enable = 1'b0; nNMI = 1'b0; pollInterrupts = 1'b1;
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        tick(10);
        pollInterrupts = 1'b0;
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL en_hold got=%h exp=%h", got, exp); end
        enable = 1'b1;
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        tick(2);
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL en_early got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFA, 1, 1));
        tick();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL en_latch got=%h exp=%h", got, exp); end
        poll();
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL en_taken got=%h exp=%h", got, exp); end
        nNMI = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_mid();
        nNMI = 1'b0;
        tick(3);
        poll();
        reset = 1'b1; nNMI = 1'b1;
        sb.push_back(mk(0, 2'b00, 8'hFC, 1, 0));
        tick();
        reset = 1'b0;
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL rmid_state got=%h exp=%h", got, exp); end
        sb.push_back(mk(1, 2'b11, 8'hFC, 0, 0));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL rmid_poll got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL rmid_taken got=%h exp=%h", got, exp); end
        tick(3);
    endtask

    task automatic test_upgrade();
        nIRQ = 1'b0; iFlag = 1'b0;
        tick(3);
        poll();
        nNMI = 1'b0;
        tick(3);
        sb.push_back(mk(1, 2'b10, 8'hFA, 0, 1));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL upg_nmi got=%h exp=%h", got, exp); end
        iFlag = 1'b1;
        sb.push_back(mk(1, 2'b10, 8'hFA, 0, 1));
        poll();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL upg_nodown got=%h exp=%h", got, exp); end
        iFlag = 1'b0;
        vectorTaken = 1'b1;
        sb.push_back(mk(1, 2'b01, 8'hFE, 0, 0));
        poll();
        vectorTaken = 1'b0;
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL upg_samecyc got=%h exp=%h", got, exp); end
        sb.push_back(mk(0, 2'b00, 8'hFE, 1, 0));
        take();
        got = obs(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++;
            $display("FAIL upg_taken got=%h exp=%h", got, exp); end
        nIRQ = 1'b1; nNMI = 1'b1; iFlag = 1'b1;
        tick(3);
    endtask

    initial begin
        #1;
        test_reset();
        test_irq();
        test_nmi_pulse();
        test_nmi_held();
        test_hijack();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_upgrade();
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu6502_interrupt_controller.md
Name: cpu6502_interrupt_controller

Overview:
Interrupt and reset front end for the 6502 core. It synchronises the external nNMI/nIRQ pins, latches NMI falling edges, and samples the interrupt condition when the microsequencer polls at an instruction boundary. It supplies the microsequencer with the pending interrupt type, and supplies the low byte of the vector address used on the ADDR_VEC bus path ({8'hFF, vectorLow}). This includes NMI hijack of BRK/IRQ sequences.

Parameters:
SYNC_STAGES, 2, number of flops in each nNMI/nIRQ synchroniser (legal range 1..4)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  clock enable; when low all state holds
nNMI  input  1  asynchronous NMI pin, active low
nIRQ  input  1  asynchronous IRQ pin, active low
iFlag  input  1  current I bit of P
pollInterrupts  input  1  microcode strobe at the instruction-boundary poll cycle
vectorTaken  input  1  microcode strobe in the cycle the vector low byte is read
interruptPending  output  1  a polled interrupt/reset is awaiting service
interruptType  output  2  00 none/BRK, 01 IRQ, 10 NMI, 11 RESET (polled type)
vectorLow  output  8  vector low byte: 8'hFC reset, 8'hFA NMI, 8'hFE IRQ/BRK
breakFlag  output  1  value of the B bit to push: 1 only when interruptType==00
nmiLatchedOut  output  1  debug view of the NMI edge latch

Behaviour:
- Enable gating: every register, including the synchroniser flops, advances only when enable=1. Reset is not gated by enable.
- Reset (reset=1 at a clock edge):
  - synchroniser flops <= 1; nmiPrev <= 1; nmiLatched <= 0.
  - resetPending <= 1; polledType <= 00.
  - Outputs after reset: interruptPending=0, interruptType=00, vectorLow=8'hFC, breakFlag=1, nmiLatchedOut=0.
- Synchronisers:
  - nmiSync and irqSync are the last stage of SYNC_STAGES flops.
  - Pin-to-sync latency is SYNC_STAGES enabled cycles.
- NMI edge detect:
  - nmiPrev <= nmiSync each enabled cycle.
  - Falling edge (nmiPrev=1, nmiSync=0) sets nmiLatched.
  - A held-low nNMI produces exactly one latch; nNMI must return high before another edge is seen.
- IRQ is level sensitive: irqActive = !irqSync && !iFlag. It is never latched.
- Poll (pollInterrupts=1, enable=1), priority resetPending > nmiLatched > irqActive:
  - polledType <= 11 / 10 / 01 respectively, else 00.
  - interruptPending = (polledType != 00), registered, so visible the cycle after the poll.
  - A poll while interruptPending=1 re-evaluates; the type may only be upgraded in priority, never downgraded.
- Vector selection is combinational and evaluated live, not at poll time:
  - vectorLow = FC if resetPending, else FA if nmiLatched, else FE.
  - Hijack: an NMI edge latched after an IRQ/BRK poll but before vectorTaken redirects that sequence to FA.
- vectorTaken (enable=1):
  - If resetPending: clear resetPending.
  - Else if nmiLatched: clear nmiLatched.
  - In all cases polledType <= 00.
  - vectorTaken with nothing pending (BRK) only confirms the FE vector.
- Simultaneous events:
  - New NMI falling edge in the same cycle as a vectorTaken that clears nmiLatched: set wins, so the latch stays 1 and the NMI is not lost.
  - pollInterrupts and vectorTaken in the same cycle: vectorTaken clears first, then the poll evaluates using post-clear state.
  - iFlag changing in the poll cycle: the value present in the poll cycle is used.
- breakFlag = (polledType == 00), registered alongside polledType.
- Reset mid-sequence: the pending NMI is discarded, resetPending=1, and the next poll yields RESET.

Test Plan:
- Reset released, enable=1, poll at cycle 3 -> interruptPending=1, interruptType=11, vectorLow=FC. vectorTaken -> pending=0, vectorLow=FE.
- After reset is serviced: nIRQ=0, iFlag=0, poll -> type=01, vectorLow=FE, breakFlag=0. Repeat with iFlag=1 -> type=00, pending=0.
- nNMI high->low pulse of 1 cycle with SYNC_STAGES=2 -> nmiLatchedOut=1 exactly 3 enabled cycles after the pin edge. Hold nNMI low for 20 cycles -> only one NMI serviced.
- Hijack: nIRQ=0 and iFlag=0, poll (type=01), then NMI edge before vectorTaken -> vectorLow switches FE->FA. vectorTaken clears nmiLatched; the IRQ is re-polled next boundary.
- NMI edge coincident with vectorTaken of a previous NMI -> nmiLatchedOut stays 1, and the next poll returns type=10.
- enable=0 for 10 cycles with an nNMI edge on the pin -> no state change. Edge latched SYNC_STAGES+1 enabled cycles after enable=1.
